// File: rtl/fm_pkg.sv
// Shared constants for the FM mix engine: sequencer state encoding and
// the fixed-point shifts used by panning and master volume.
package fm_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_PROCESS = 3'd2;
    localparam logic [2:0] ST_NEXT    = 3'd3;
    localparam logic [2:0] ST_OUTPUT  = 3'd4;

    localparam logic [7:0]  VOL_UNITY = 8'h80;
    localparam int unsigned PAN_SHIFT = 8;
    localparam int unsigned VOL_SHIFT = 7;

endpackage

// File: rtl/fm_sat_scale.sv
// Applies master volume to a signed mix accumulator and saturates the
// result to the signed audio output range.
module fm_sat_scale
    import fm_pkg::*;
#(
    parameter int ACC_W     = 19,
    parameter int OUT_WIDTH = 16
) (
    input  logic signed [ACC_W-1:0]     acc,
    input  logic        [7:0]           volume,
    output logic signed [OUT_WIDTH-1:0] sat
);

    localparam int SW = ACC_W + 9;
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [SW-1:0] acc_ext;
    logic signed [SW-1:0] vol_ext;
    logic signed [SW-1:0] scaled;

    assign acc_ext = SW'(acc);
    assign vol_ext = SW'(volume);
    assign scaled  = (acc_ext * vol_ext) >>> VOL_SHIFT;

    always_comb begin
        sat = scaled[OUT_WIDTH-1:0];
        if (scaled > SAT_MAX) begin
            sat = SAT_MAX[OUT_WIDTH-1:0];
        end else if (scaled < SAT_MIN) begin
            sat = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fm_mix_seq.sv
// Slot sequencer and stereo mix engine: sample tick generation, per-slot
// operator stepping, panned accumulation and volume-scaled stereo output.
module fm_mix_seq
    import fm_pkg::*;
#(
    parameter int NUM_OPS    = 64,
    parameter int SAMPLE_DIV = 506,
    parameter int IN_WIDTH   = 13,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [7:0]                  volume,
    input  logic signed [IN_WIDTH-1:0]  op_result,
    input  logic                        do_sum,
    input  logic [7:0]                  pan_l,
    input  logic [7:0]                  pan_r,
    output logic [$clog2(NUM_OPS)-1:0]  op_sel,
    output logic                        op_next,
    output logic                        op_reset,
    output logic                        busy,
    output logic [OUT_WIDTH-1:0]        audio_l,
    output logic [OUT_WIDTH-1:0]        audio_r,
    output logic                        audio_valid,
    input  logic                        audio_ready,
    output logic [7:0]                  overrun_cnt
);

    localparam int SEL_W = $clog2(NUM_OPS);
    localparam int ACC_W = IN_WIDTH + SEL_W;
    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam int PW    = IN_WIDTH + 9;

    logic [CNT_W-1:0]          div_cnt;
    logic                      tick;
    logic [2:0]                state;
    logic signed [ACC_W-1:0]   acc_l;
    logic signed [ACC_W-1:0]   acc_r;
    logic signed [PW-1:0]      op_ext;
    logic signed [PW-1:0]      pan_l_ext;
    logic signed [PW-1:0]      pan_r_ext;
    logic signed [IN_WIDTH-1:0] panned_l;
    logic signed [IN_WIDTH-1:0] panned_r;
    logic signed [OUT_WIDTH-1:0] sat_l;
    logic signed [OUT_WIDTH-1:0] sat_r;
    logic                      overrun_evt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (div_cnt == CNT_W'(SAMPLE_DIV - 1));
            div_cnt <= (div_cnt == CNT_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt + 1'b1;
        end
    end

    // Product formed at full width before the shift, then truncated.
    assign op_ext    = PW'(op_result);
    assign pan_l_ext = PW'(pan_l);
    assign pan_r_ext = PW'(pan_r);
    assign panned_l  = IN_WIDTH'((op_ext * pan_l_ext) >>> PAN_SHIFT);
    assign panned_r  = IN_WIDTH'((op_ext * pan_r_ext) >>> PAN_SHIFT);

    assign op_next     = (state == ST_NEXT);
    assign busy        = (state != ST_IDLE);
    // A dropped tick and an unread-sample overwrite share one increment.
    assign overrun_evt = (tick && busy) ||
                         (state == ST_OUTPUT && audio_valid && !audio_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            op_sel      <= '0;
            op_reset    <= 1'b1;
            acc_l       <= '0;
            acc_r       <= '0;
            audio_l     <= '0;
            audio_r     <= '0;
            audio_valid <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            if (overrun_evt && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
            if (audio_valid && audio_ready) begin
                audio_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (tick && enable) state <= ST_START;
                end
                ST_START: begin
                    op_sel <= '0;
                    state  <= ST_PROCESS;
                end
                ST_PROCESS: begin
                    if (!op_reset && do_sum) begin
                        acc_l <= acc_l + ACC_W'(panned_l);
                        acc_r <= acc_r + ACC_W'(panned_r);
                    end
                    state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (op_sel == SEL_W'(NUM_OPS - 1)) begin
                        state <= ST_OUTPUT;
                    end else begin
                        op_sel <= op_sel + 1'b1;
                        state  <= ST_PROCESS;
                    end
                end
                ST_OUTPUT: begin
                    audio_l     <= sat_l;
                    audio_r     <= sat_r;
                    audio_valid <= 1'b1;
                    acc_l       <= '0;
                    acc_r       <= '0;
                    op_reset    <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fm_sat_scale #(.ACC_W(ACC_W), .OUT_WIDTH(OUT_WIDTH)) u_scale_l (
        .acc    (acc_l),
        .volume (volume),
        .sat    (sat_l)
    );

    fm_sat_scale #(.ACC_W(ACC_W), .OUT_WIDTH(OUT_WIDTH)) u_scale_r (
        .acc    (acc_r),
        .volume (volume),
        .sat    (sat_r)
    );

endmodule

// File: tb/tb_fm_mix_seq.sv
// Self-checking bench for fm_mix_seq: default-size instance for mixing,
// saturation, handshake, enable and reset; a tiny instance for tick drops.
module tb_fm_mix_seq;
    import fm_pkg::*;

    localparam int N    = 64;
    localparam int DIV  = 506;
    localparam int FN   = 4;
    localparam int FDIV = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n;
    logic               enable;
    logic [7:0]         volume;
    logic signed [12:0] op_result;
    logic               do_sum;
    logic [7:0]         pan_l, pan_r;
    logic [5:0]         op_sel;
    logic               op_next, op_reset, busy;
    logic [15:0]        audio_l, audio_r;
    logic               audio_valid, audio_ready;
    logic [7:0]         overrun_cnt;

    logic signed [12:0] res_tab [N];
    logic               sum_tab [N];
    logic [7:0]         pl_tab  [N];
    logic [7:0]         pr_tab  [N];

    assign op_result = res_tab[op_sel];
    assign do_sum    = sum_tab[op_sel];
    assign pan_l     = pl_tab[op_sel];
    assign pan_r     = pr_tab[op_sel];

    fm_mix_seq u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .volume      (volume),
        .op_result   (op_result),
        .do_sum      (do_sum),
        .pan_l       (pan_l),
        .pan_r       (pan_r),
        .op_sel      (op_sel),
        .op_next     (op_next),
        .op_reset    (op_reset),
        .busy        (busy),
        .audio_l     (audio_l),
        .audio_r     (audio_r),
        .audio_valid (audio_valid),
        .audio_ready (audio_ready),
        .overrun_cnt (overrun_cnt)
    );

    logic        f_rst_n;
    logic [1:0]  f_op_sel;
    logic        f_op_next, f_op_reset, f_busy, f_valid;
    logic [15:0] f_audio_l, f_audio_r;
    logic [7:0]  f_ovr;

    fm_mix_seq #(.NUM_OPS(FN), .SAMPLE_DIV(FDIV)) u_fast (
        .clk         (clk),
        .reset_n     (f_rst_n),
        .enable      (1'b1),
        .volume      (VOL_UNITY),
        .op_result   (13'sd0),
        .do_sum      (1'b0),
        .pan_l       (8'h80),
        .pan_r       (8'h80),
        .op_sel      (f_op_sel),
        .op_next     (f_op_next),
        .op_reset    (f_op_reset),
        .busy        (f_busy),
        .audio_l     (f_audio_l),
        .audio_r     (f_audio_r),
        .audio_valid (f_valid),
        .audio_ready (1'b1),
        .overrun_cnt (f_ovr)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit first_done;
    bit valid_pending;
    int exp_ovr;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input bit rnd, input int r, input logic [7:0] p);
        for (int i = 0; i < N; i++) begin
            if (rnd) begin
                res_tab[i] = 13'($urandom);
                sum_tab[i] = 1'($urandom_range(0, 1));
                pl_tab[i]  = 8'($urandom);
                pr_tab[i]  = 8'($urandom);
            end else begin
                res_tab[i] = 13'(r);
                sum_tab[i] = 1'b1;
                pl_tab[i]  = p;
                pr_tab[i]  = p;
            end
        end
    endtask

    // Mix of one sample: floor-panned carriers summed, volume /128, clamped.
    function automatic longint exp_chan(input bit left, input logic [7:0] vol);
        longint acc = 0;
        longint pv;
        longint s;
        for (int i = 0; i < N; i++) begin
            if (sum_tab[i]) begin
                pv  = left ? longint'(pl_tab[i]) : longint'(pr_tab[i]);
                acc += (longint'(res_tab[i]) * pv) >>> 8;
            end
        end
        s = (acc * longint'(vol)) >>> 7;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    task automatic run_pass(input string tag, input int drop_en_at);
        int     waited = 0;
        int     len = 0;
        int     nexts = 0;
        longint el, er;
        el = first_done ? exp_chan(1'b1, volume) : 0;
        er = first_done ? exp_chan(1'b0, volume) : 0;
        while (busy !== 1'b1 && waited < 2 * DIV + 20) begin
            @(negedge clk);
            waited++;
        end
        if (busy !== 1'b1) begin
            check({tag, "_start_timeout"}, 0, 1);
            return;
        end
        check({tag, "_op_reset"}, op_reset, first_done ? 0 : 1);
        while (busy === 1'b1 && len < 2 * N + 10) begin
            @(negedge clk);
            len++;
            if (op_next === 1'b1) nexts++;
            if (len == drop_en_at) enable = 1'b0;
        end
        check({tag, "_len"}, len, 2 * N + 2);
        check({tag, "_nexts"}, nexts, N);
        if (valid_pending) exp_ovr++;
        valid_pending = 1'b1;
        first_done    = 1'b1;
        check({tag, "_valid"}, audio_valid, 1);
        check({tag, "_l"}, longint'($signed(audio_l)), el);
        check({tag, "_r"}, longint'($signed(audio_r)), er);
        check({tag, "_op_reset_clr"}, op_reset, 0);
        check({tag, "_ovr"}, overrun_cnt, exp_ovr);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        audio_ready = 1'b1;
        @(negedge clk);
        audio_ready = 1'b0;
        check({tag, "_valid_clear"}, audio_valid, 0);
        valid_pending = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_op_sel"}, op_sel, 0);
        check({tag, "_op_next"}, op_next, 0);
        check({tag, "_op_reset"}, op_reset, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_audio_l"}, audio_l, 0);
        check({tag, "_audio_r"}, audio_r, 0);
        check({tag, "_valid"}, audio_valid, 0);
        check({tag, "_ovr"}, overrun_cnt, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_busy = 0;
        int cur = 0;
        int passes = 0;
        int acc_ticks = 0;
        int drop_ticks = 0;
        int free_at = 0;
        int seen;

        reset_n     = 1'b0;
        f_rst_n     = 1'b0;
        enable      = 1'b0;
        audio_ready = 1'b0;
        volume      = VOL_UNITY;
        fill(1'b0, 0, 8'h00);
        repeat (3) @(negedge clk);

        // Tiny instance: pass outlasts the sample period, so ticks collide.
        f_rst_n = 1'b1;
        for (int cyc = 1; cyc <= 20 * FDIV + 4; cyc++) begin
            @(negedge clk);
            if (f_busy && prev_busy == 0) begin
                passes++;
                cur = 0;
            end
            if (f_op_next) cur++;
            if (!f_busy && prev_busy == 1) check("fast_nexts", cur, FN);
            prev_busy = f_busy ? 1 : 0;
        end
        for (int k = 1; k <= 20; k++) begin
            if (k * FDIV >= free_at) begin
                acc_ticks++;
                free_at = k * FDIV + 2 * FN + 3;
            end else begin
                drop_ticks++;
            end
        end
        check("fast_passes", passes, acc_ticks);
        check("fast_ovr", f_ovr, drop_ticks);

        check_reset_vals("rst");

        first_done    = 1'b0;
        valid_pending = 1'b0;
        exp_ovr       = 0;
        @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b1;

        fill(1'b0, 100, 8'hFF);
        volume = VOL_UNITY;
        run_pass("p1", 0);
        consume("p1");
        run_pass("p2", 0);
        check("p2_const", longint'($signed(audio_l)), 6336);
        consume("p2");

        for (int k = 0; k < 6; k++) begin
            fill(1'b1, 0, 8'h00);
            volume = 8'($urandom);
            run_pass($sformatf("rnd%0d", k), 0);
            consume($sformatf("rnd%0d", k));
        end

        fill(1'b0, 4095, 8'hFF);
        volume = 8'hFF;
        run_pass("sat_pos", 0);
        check("sat_pos_const", audio_l, 16'h7FFF);
        consume("sat_pos");
        fill(1'b0, -4096, 8'hFF);
        run_pass("sat_neg", 0);
        check("sat_neg_const", audio_r, 16'h8000);
        consume("sat_neg");

        volume = VOL_UNITY;
        for (int k = 0; k < 3; k++) begin
            fill(1'b1, 0, 8'h00);
            run_pass($sformatf("ovr%0d", k), 0);
        end
        check("ovr_total", overrun_cnt, 2);
        consume("ovr");

        fill(1'b1, 0, 8'h00);
        run_pass("en_drop", 20);
        seen = 0;
        for (int c = 0; c < 2 * DIV + 20; c++) begin
            @(negedge clk);
            if (busy) seen++;
        end
        check("en_drop_no_busy", seen, 0);
        consume("en_drop");

        enable = 1'b1;
        seen = 0;
        while (busy !== 1'b1 && seen < 2 * DIV + 20) begin
            @(negedge clk);
            seen++;
        end
        check("mid_rst_started", busy, 1);
        repeat (30) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fm_mix_seq.md
# fm_mix_seq

Parametrised slot sequencer and stereo mix engine for the next-generation FM synthesizer. It generates the sample-rate tick and steps an operator-slot index through every slot once per sample. It accumulates the panned per-slot operator output, applies master volume with saturation, and presents the stereo sample over a valid/ready handshake. The envelope, phase and operator datapath sit outside this block and are driven by its `op_sel`/`op_next`/`op_reset` outputs; `busy` feeds the register block's bus-wait logic.

## Interface
- `NUM_OPS`, 64: operator slots per sample; power of two, ≥2.
- `SAMPLE_DIV`, 506: clocks per sample tick; must be ≥ 2·NUM_OPS+4.
- `IN_WIDTH`, 13: signed operator result width.
- `OUT_WIDTH`, 16: signed audio output width.
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: when low, new passes are not started.
- `volume` in 8: unsigned master gain; 0x80 = unity.
- `op_result` in IN_WIDTH: signed result for the current `op_sel`, valid in PROCESS.
- `do_sum` in 1: the current slot is a carrier and is added to the mix.
- `pan_l`, `pan_r` in 8 each: unsigned pan gains for the current slot; 0x80 = half, 0xFF ≈ full.
- `op_sel` out log2(NUM_OPS): current slot index.
- `op_next` out 1: one-cycle pulse that commits the current slot's state in the external datapath.
- `op_reset` out 1: high until the first complete pass after reset.
- `busy` out 1: a pass is in progress (state ≠ IDLE).
- `audio_l`, `audio_r` out OUT_WIDTH each: held output sample.
- `audio_valid` out 1 / `audio_ready` in 1: output handshake.
- `overrun_cnt` out 8: saturating count of lost samples and skipped ticks.

## Operation
- **Tick counter.** Free-runs 0..SAMPLE_DIV−1. A one-cycle `tick` is registered on wrap. The counter is independent of `enable` and of the state machine.
- **States: IDLE → START → PROCESS ⇄ NEXT → OUTPUT → IDLE.**
  - IDLE: on `tick` with `enable` high, go to START.
  - START: `op_sel`←0, go to PROCESS.
  - PROCESS: if `!op_reset && do_sum`, add the panned values to the accumulators. Assert `op_next` in the next cycle. Go to NEXT.
  - NEXT: if `op_sel` = NUM_OPS−1, go to OUTPUT. Otherwise increment `op_sel` and go to PROCESS.
  - OUTPUT: scale and saturate, load the output registers, clear the accumulators, clear `op_reset`, go to IDLE.
- **Panning.** `panned = (op_result · {0,pan}) >>> 8`, truncated to IN_WIDTH signed bits.
- **Accumulators.** Signed, ACC_W = IN_WIDTH + log2(NUM_OPS) bits, sign-extended adds. By construction they cannot overflow.
- **Volume.** `scaled = (acc · {0,volume}) >>> 7`, computed at ACC_W+9 bits.
- **Saturation.** `scaled` saturates to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
- **Output handshake.** OUTPUT always loads `audio_l`/`audio_r` and sets `audio_valid`. If `audio_valid && !audio_ready` at that moment, the unread sample is overwritten and `overrun_cnt` increments. `audio_valid` clears on the cycle after `valid && ready`.
- **Tick while busy.** A `tick` arriving while state ≠ IDLE is dropped and `overrun_cnt` increments. The pass in progress completes normally.
- **`enable` dropped mid-pass.** The current pass completes; no new pass starts.
- **Simultaneous events.** A tick and the OUTPUT state in the same cycle count as a dropped tick. `overrun_cnt` increments by at most 1 per cycle and holds at 0xFF.

## Timing
- **Reset values:** state IDLE, `op_sel`=0, `op_next`=0, `op_reset`=1, `busy`=0, `audio_l`/`audio_r`=0, `audio_valid`=0, `overrun_cnt`=0, accumulators 0, tick counter 0.
- **Reset mid-pass:** everything returns to the reset values immediately, including `op_reset`=1.
- **Pass length:** 2·NUM_OPS+2 cycles from START to OUTPUT inclusive.
- **Latency:** `audio_valid` rises 2·NUM_OPS+3 cycles after the `tick` cycle.
- `op_next` pulses exactly once per slot, in the cycle where state = NEXT.
- `op_sel` is stable across each PROCESS/NEXT pair.
- `volume` is sampled in OUTPUT only.

## Structure
- **Shared package `fm_pkg`:** state encoding (IDLE..OUTPUT), `VOL_UNITY`=8'h80, `PAN_SHIFT`=8, `VOL_SHIFT`=7.
- **Sub-module `fm_sat_scale`:** combinational. Takes a signed accumulator and `volume`, returns the saturated OUT_WIDTH value. It is instantiated twice, once for L and once for R.

## Test plan
- **Default parameters, first pass after reset.** All slots `do_sum`=1, `op_result`=100, pans 0xFF → first sample is 0 with `op_reset` high; it falls after OUTPUT. Second sample: 64·99 = 6336 each channel at unity volume.
- **Saturation.** `op_result`=+4095, all `do_sum`, pans 0xFF, `volume`=0xFF → `audio_l`=`audio_r`=0x7FFF. With `op_result`=−4096 → 0x8000.
- **Handshake and overrun.** Hold `audio_ready`=0 across 3 samples → `overrun_cnt`=2 and the latest sample is visible. Raise `audio_ready` for one cycle → `audio_valid` drops next cycle.
- **Tick during a pass.** Use SAMPLE_DIV < pass length (NUM_OPS=4, SAMPLE_DIV=8) → every other tick is dropped, `overrun_cnt` increments per dropped tick, and every pass still has exactly 4 `op_next` pulses.
- **`enable` and reset.** Drop `enable` mid-pass → the pass completes and no further `busy`. Assert `reset_n` low mid-pass → all outputs return to reset values within the same cycle and `op_reset`=1.
